// File: rtl/ucb_nibble_rx_if.sv
// ucb_nibble_rx_if: bundles the nibble link (vld/data/stall) and the packet
// holding-register handshake (pkt_* / ack) plus the error flag/clear.
// Modports: slave = the receiver block, master = link sender / CSR consumer.
interface ucb_nibble_rx_if #(
  parameter int BUS_WIDTH  = 4,
  parameter int HDR_WIDTH  = 64,
  parameter int DATA_WIDTH = 64
);
  logic                  ucb_rx_vld;
  logic [BUS_WIDTH-1:0]  ucb_rx_data;
  logic                  ucb_rx_stall;
  logic                  pkt_vld;
  logic [HDR_WIDTH-1:0]  pkt_hdr;
  logic [DATA_WIDTH-1:0] pkt_data;
  logic                  pkt_has_data;
  logic                  pkt_ack;
  logic                  rx_err;
  logic                  rx_err_clr;

  modport slave (
    input  ucb_rx_vld, ucb_rx_data, pkt_ack, rx_err_clr,
    output ucb_rx_stall, pkt_vld, pkt_hdr, pkt_data, pkt_has_data, rx_err
  );

  modport master (
    output ucb_rx_vld, ucb_rx_data, pkt_ack, rx_err_clr,
    input  ucb_rx_stall, pkt_vld, pkt_hdr, pkt_data, pkt_has_data, rx_err
  );
endinterface

// File: rtl/ucb_nibble_rx.sv
// ucb_nibble_rx: reassembles UCB packets (64b header + optional 64b payload for
// WRITE_REQ) from a nibble link, LS nibble first, and holds one packet for the
// CSR side behind a valid/ack handshake. One extra packet can park in the
// assembly register while the holding register is full (skid entry).
// Latency: pkt_vld rises one cycle after the last beat when holding is empty.
// Backpressure: ucb_rx_stall (registered) is high while holding is full or a
// completed packet is parked; beats arriving while parked are dropped and flag rx_err.
// Ports: jbus_gclk, jbus_arst_l (async active-low), rx (ucb_nibble_rx_if.slave).
// Optional: define UCB_RX_TIMEOUT_EN to abandon a packet after TIMEOUT idle cycles.
module ucb_nibble_rx #(
  parameter int BUS_WIDTH  = 4,
  parameter int HDR_WIDTH  = 64,
  parameter int DATA_WIDTH = 64,
  parameter int TIMEOUT    = 255
) (
  input logic            jbus_gclk,
  input logic            jbus_arst_l,
  ucb_nibble_rx_if.slave rx
);

  localparam int HDR_BEATS  = HDR_WIDTH / BUS_WIDTH;
  localparam int DATA_BEATS = DATA_WIDTH / BUS_WIDTH;
  localparam int MAX_BEATS  = (HDR_BEATS > DATA_BEATS) ? HDR_BEATS : DATA_BEATS;
  localparam int CNT_W      = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_BEATS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BEATS - 1);
  localparam logic [3:0] OPC_WRITE_REQ = 4'b0101;
  localparam logic [3:0] OPC_MAX       = 4'b0110;

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA, ST_DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [HDR_WIDTH-1:0]  asm_hdr_q, asm_hdr_d;
  logic [DATA_WIDTH-1:0] asm_data_q, asm_data_d;
  logic                  asm_wr_q, asm_wr_d;
  logic                  pkt_vld_q, pkt_vld_d;
  logic [HDR_WIDTH-1:0]  pkt_hdr_q, pkt_hdr_d;
  logic [DATA_WIDTH-1:0] pkt_data_q, pkt_data_d;
  logic                  pkt_has_data_q, pkt_has_data_d;
  logic                  stall_q, stall_d;
  logic                  rx_err_q, rx_err_d;

  // Assembly register contents with the current beat merged in.
  logic [HDR_WIDTH-1:0]  hdr_nxt;
  logic [DATA_WIDTH-1:0] data_nxt;
  // Packet ready to hand over this cycle, and its contents.
  logic                  pkt_done;
  logic [HDR_WIDTH-1:0]  done_hdr;
  logic [DATA_WIDTH-1:0] done_data;
  logic                  done_wr;
  logic                  pop;
  logic                  err_set;

`ifdef UCB_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] idle_q, idle_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    asm_hdr_d      = asm_hdr_q;
    asm_data_d     = asm_data_q;
    asm_wr_d       = asm_wr_q;
    pkt_vld_d      = pkt_vld_q;
    pkt_hdr_d      = pkt_hdr_q;
    pkt_data_d     = pkt_data_q;
    pkt_has_data_d = pkt_has_data_q;
    err_set        = 1'b0;
    pkt_done       = 1'b0;
    done_hdr       = asm_hdr_q;
    done_data      = asm_data_q;
    done_wr        = asm_wr_q;
    pop            = rx.pkt_ack & pkt_vld_q;

    hdr_nxt  = asm_hdr_q;
    data_nxt = asm_data_q;
    for (int i = 0; i < HDR_BEATS; i++) begin
      if (cnt_q == CNT_W'(i)) hdr_nxt[i*BUS_WIDTH +: BUS_WIDTH] = rx.ucb_rx_data;
    end
    for (int i = 0; i < DATA_BEATS; i++) begin
      if (cnt_q == CNT_W'(i)) data_nxt[i*BUS_WIDTH +: BUS_WIDTH] = rx.ucb_rx_data;
    end

    case (state_q)
      ST_IDLE: begin
        // cnt_q is always 0 here, so this beat lands at offset 0.
        if (rx.ucb_rx_vld) begin
          asm_hdr_d = hdr_nxt;
          cnt_d     = CNT_W'(1);
          state_d   = ST_HDR;
        end
      end
      ST_HDR: begin
        if (rx.ucb_rx_vld) begin
          asm_hdr_d = hdr_nxt;
          if (cnt_q == HDR_LAST) begin
            cnt_d = '0;
            if (hdr_nxt[3:0] > OPC_MAX) err_set = 1'b1;
            if (hdr_nxt[3:0] == OPC_WRITE_REQ) begin
              asm_wr_d = 1'b1;
              state_d  = ST_DATA;
            end else begin
              asm_wr_d = 1'b0;
              pkt_done = 1'b1;
              done_hdr = hdr_nxt;
              done_wr  = 1'b0;
              state_d  = ST_DONE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (rx.ucb_rx_vld) begin
          asm_data_d = data_nxt;
          if (cnt_q == DATA_LAST) begin
            cnt_d     = '0;
            pkt_done  = 1'b1;
            done_data = data_nxt;
            done_wr   = 1'b1;
            state_d   = ST_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin // ST_DONE: parked packet, no room for more beats
        pkt_done = 1'b1;
        if (rx.ucb_rx_vld) err_set = 1'b1;
      end
    endcase

`ifdef UCB_RX_TIMEOUT_EN
    idle_d = '0;
    if (state_q == ST_HDR || state_q == ST_DATA) begin
      if (!rx.ucb_rx_vld) begin
        if (idle_q == TO_W'(TIMEOUT - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          err_set = 1'b1;
        end else begin
          idle_d = idle_q + TO_W'(1);
        end
      end
    end
`endif

    // Hand the finished packet straight to holding when there is room,
    // including the cycle the current occupant is popped.
    if (pkt_done && (!pkt_vld_q || pop)) begin
      pkt_vld_d      = 1'b1;
      pkt_hdr_d      = done_hdr;
      pkt_data_d     = done_wr ? done_data : '0;
      pkt_has_data_d = done_wr;
      state_d        = ST_IDLE;
    end else if (pop) begin
      pkt_vld_d = 1'b0;
    end

    stall_d  = pkt_vld_d | (state_d == ST_DONE);
    rx_err_d = (rx_err_q & ~rx.rx_err_clr) | err_set;
  end

  always_ff @(posedge jbus_gclk or negedge jbus_arst_l) begin
    if (!jbus_arst_l) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      asm_hdr_q      <= '0;
      asm_data_q     <= '0;
      asm_wr_q       <= 1'b0;
      pkt_vld_q      <= 1'b0;
      pkt_hdr_q      <= '0;
      pkt_data_q     <= '0;
      pkt_has_data_q <= 1'b0;
      stall_q        <= 1'b0;
      rx_err_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      asm_hdr_q      <= asm_hdr_d;
      asm_data_q     <= asm_data_d;
      asm_wr_q       <= asm_wr_d;
      pkt_vld_q      <= pkt_vld_d;
      pkt_hdr_q      <= pkt_hdr_d;
      pkt_data_q     <= pkt_data_d;
      pkt_has_data_q <= pkt_has_data_d;
      stall_q        <= stall_d;
      rx_err_q       <= rx_err_d;
    end
  end

`ifdef UCB_RX_TIMEOUT_EN
  always_ff @(posedge jbus_gclk or negedge jbus_arst_l) begin
    if (!jbus_arst_l) idle_q <= '0;
    else              idle_q <= idle_d;
  end
`endif

  assign rx.ucb_rx_stall = stall_q;
  assign rx.pkt_vld      = pkt_vld_q;
  assign rx.pkt_hdr      = pkt_hdr_q;
  assign rx.pkt_data     = pkt_data_q;
  assign rx.pkt_has_data = pkt_has_data_q;
  assign rx.rx_err       = rx_err_q;

endmodule

// File: tb/tb_ucb_nibble_rx.sv
// tb_ucb_nibble_rx: directed stimulus for ucb_nibble_rx with a nibble-queue
// reference model compared every cycle, plus literal expectations per scenario.
module tb_ucb_nibble_rx;
  localparam int TB_TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ucb_nibble_rx_if #(.BUS_WIDTH(4), .HDR_WIDTH(64), .DATA_WIDTH(64)) bus ();

  ucb_nibble_rx #(.BUS_WIDTH(4), .HDR_WIDTH(64), .DATA_WIDTH(64), .TIMEOUT(TB_TIMEOUT)) dut (
    .jbus_gclk   (clk),
    .jbus_arst_l (rst_n),
    .rx          (bus)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model (nibble queue + parked/holding packets)
  logic [3:0]  beats[$];
  logic        m_vld, m_has, m_err, m_stall, park, park_wr;
  logic [63:0] m_hdr, m_data, park_hdr, park_data;
  int          idle;

  function automatic logic [63:0] pack(input int first);
    logic [63:0] r = '0;
    for (int k = 0; k < 16; k++) r = r | (64'(beats[first + k]) << (4 * k));
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic p, p0, w, e, pop, mv;
    logic [63:0] h, d;
    int idle_n;
    if (!rst_n) begin
      beats.delete();
      m_vld <= 0; m_has <= 0; m_err <= 0; m_stall <= 0; park <= 0; park_wr <= 0;
      m_hdr <= '0; m_data <= '0; park_hdr <= '0; park_data <= '0; idle <= 0;
    end else begin
      p0 = park; p = park; h = park_hdr; d = park_data; w = park_wr;
      e = m_err & ~bus.rx_err_clr;
      pop = bus.pkt_ack & m_vld;
      mv = m_vld;
      idle_n = idle;
      if (bus.ucb_rx_vld) begin
        if (p0) e = 1'b1;
        else beats.push_back(bus.ucb_rx_data);
      end
      if (bus.ucb_rx_vld && !p0 && beats.size() == 16) begin
        h = pack(0);
        if (h[3:0] > 4'd6) e = 1'b1;
        if (h[3:0] != 4'd5) begin
          p = 1'b1; d = '0; w = 1'b0; beats.delete();
        end
      end else if (bus.ucb_rx_vld && !p0 && beats.size() == 32) begin
        h = pack(0); d = pack(16); w = 1'b1; p = 1'b1; beats.delete();
      end
`ifdef UCB_RX_TIMEOUT_EN
      if (bus.ucb_rx_vld || beats.size() == 0 || p0) idle_n = 0;
      else begin
        idle_n = idle + 1;
        if (idle_n == TB_TIMEOUT) begin
          beats.delete(); e = 1'b1; idle_n = 0;
        end
      end
`endif
      if (p && (!m_vld || pop)) begin
        mv = 1'b1; p = 1'b0;
        m_hdr <= h; m_data <= w ? d : '0; m_has <= w;
      end else if (pop) begin
        mv = 1'b0;
      end
      m_vld <= mv; m_stall <= mv | p; m_err <= e;
      park <= p; park_hdr <= h; park_data <= d; park_wr <= w; idle <= idle_n;
    end
  end

  // ---------------- per-cycle compare against the model
  always @(negedge clk) begin
    checks++;
    if (bus.pkt_vld !== m_vld || bus.pkt_hdr !== m_hdr || bus.pkt_data !== m_data ||
        bus.pkt_has_data !== m_has || bus.rx_err !== m_err || bus.ucb_rx_stall !== m_stall) begin
      errors++;
      $display("FAIL model_cmp t=%0t got vld=%b hdr=%h data=%h has=%b err=%b stall=%b required vld=%b hdr=%h data=%h has=%b err=%b stall=%b",
               $time, bus.pkt_vld, bus.pkt_hdr, bus.pkt_data, bus.pkt_has_data, bus.rx_err, bus.ucb_rx_stall,
               m_vld, m_hdr, m_data, m_has, m_err, m_stall);
    end
  end

  // ---------------- stimulus helpers
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic [3:0] d, input logic a, input logic c);
    @(posedge clk);
    #1;
    bus.ucb_rx_vld = v; bus.ucb_rx_data = d; bus.pkt_ack = a; bus.rx_err_clr = c;
  endtask

  task automatic send_beats(input logic [127:0] bits, input int first, input int last,
                            input int gap_after, input int gap_len);
    for (int i = first; i <= last; i++) begin
      step(1'b1, bits[4*i +: 4], 1'b0, 1'b0);
      if (i == gap_after) repeat (gap_len) step(1'b0, 4'h0, 1'b0, 1'b0);
    end
  endtask

  task automatic pop_pkt();
    step(1'b0, 4'h0, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  localparam logic [63:0] H_RR   = 64'h0000_0000_0000_1234;
  localparam logic [63:0] H_WR   = 64'h0000_0000_0000_ABC5;
  localparam logic [63:0] D_WR   = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [63:0] H_ACK1 = 64'h1111_0000_0000_0001;
  localparam logic [63:0] H_ACK2 = 64'h2222_0000_0000_0001;
  localparam logic [63:0] H_BAD  = 64'h0000_0000_5555_000F;
  localparam logic [63:0] H_RR2  = 64'h0000_0000_0000_5674;
  localparam logic [63:0] H_PART = 64'h0000_0000_0000_7654;
  localparam logic [63:0] H_RA   = 64'h0000_0000_0000_9871;

  initial begin
    rst_n = 1'b0;
    bus.ucb_rx_vld = 1'b0; bus.ucb_rx_data = 4'h0; bus.pkt_ack = 1'b0; bus.rx_err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pkt_vld", 64'(bus.pkt_vld), 64'd0);
    check("rst_pkt_hdr", bus.pkt_hdr, 64'd0);
    check("rst_pkt_data", bus.pkt_data, 64'd0);
    check("rst_has_data", 64'(bus.pkt_has_data), 64'd0);
    check("rst_stall", 64'(bus.ucb_rx_stall), 64'd0);
    check("rst_rx_err", 64'(bus.rx_err), 64'd0);
    rst_n = 1'b1;

    // READ_REQ, 16 beats with no gaps
    send_beats({64'd0, H_RR}, 0, 15, -1, 0);
    check("rr_vld_before_last", 64'(bus.pkt_vld), 64'd0);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    check("rr_vld", 64'(bus.pkt_vld), 64'd1);
    check("rr_hdr", bus.pkt_hdr, H_RR);
    check("rr_has", 64'(bus.pkt_has_data), 64'd0);
    check("rr_data", bus.pkt_data, 64'd0);
    check("rr_err", 64'(bus.rx_err), 64'd0);
    check("rr_stall", 64'(bus.ucb_rx_stall), 64'd1);
    pop_pkt();
    check("rr_pop_vld", 64'(bus.pkt_vld), 64'd0);
    check("rr_pop_stall", 64'(bus.ucb_rx_stall), 64'd0);

    // WRITE_REQ with a 3-cycle gap after beat 7
    send_beats({D_WR, H_WR}, 0, 31, 6, 3);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    check("wr_vld", 64'(bus.pkt_vld), 64'd1);
    check("wr_hdr", bus.pkt_hdr, H_WR);
    check("wr_data", bus.pkt_data, 64'hDEADBEEFCAFEF00D);
    check("wr_has", 64'(bus.pkt_has_data), 64'd1);
    pop_pkt();

    // Back-pressure: two READ_ACKs back to back, no ack
    send_beats({64'd0, H_ACK1}, 0, 15, -1, 0);
    send_beats({64'd0, H_ACK2}, 0, 0, -1, 0);
    check("bp_stall_after_first", 64'(bus.ucb_rx_stall), 64'd1);
    check("bp_vld_first", 64'(bus.pkt_vld), 64'd1);
    send_beats({64'd0, H_ACK2}, 1, 15, -1, 0);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    check("bp_hold_hdr1", bus.pkt_hdr, H_ACK1);
    check("bp_stall_parked", 64'(bus.ucb_rx_stall), 64'd1);
    // beat while parked, with a coincident clear: set must win
    step(1'b1, 4'h3, 1'b0, 1'b1);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    check("bp_err_done_beat", 64'(bus.rx_err), 64'd1);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    check("bp_vld_stays", 64'(bus.pkt_vld), 64'd1);
    check("bp_hold_hdr2", bus.pkt_hdr, H_ACK2);
    check("bp_stall_hdr2", 64'(bus.ucb_rx_stall), 64'd1);
    pop_pkt();
    check("bp_empty", 64'(bus.pkt_vld), 64'd0);
    check("bp_stall_clear", 64'(bus.ucb_rx_stall), 64'd0);
    step(1'b0, 4'h0, 1'b0, 1'b1);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    check("bp_err_cleared", 64'(bus.rx_err), 64'd0);

    // Bad opcode: delivered, error flagged, then cleared; packet left held
    send_beats({64'd0, H_BAD}, 0, 15, -1, 0);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    check("bad_vld", 64'(bus.pkt_vld), 64'd1);
    check("bad_hdr", bus.pkt_hdr, H_BAD);
    check("bad_err", 64'(bus.rx_err), 64'd1);
    step(1'b0, 4'h0, 1'b0, 1'b1);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    check("bad_err_clr", 64'(bus.rx_err), 64'd0);

    // Reset after beat 9 of a WRITE_REQ
    send_beats({D_WR, H_WR}, 0, 8, -1, 0);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", 64'(bus.pkt_vld), 64'd0);
    check("mid_rst_hdr", bus.pkt_hdr, 64'd0);
    check("mid_rst_stall", 64'(bus.ucb_rx_stall), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_beats({64'd0, H_RR2}, 0, 15, -1, 0);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    check("post_rst_vld", 64'(bus.pkt_vld), 64'd1);
    check("post_rst_hdr", bus.pkt_hdr, H_RR2);
    check("post_rst_data", bus.pkt_data, 64'd0);
    pop_pkt();

    // Stall after beat 5
    send_beats({64'd0, H_PART}, 0, 4, -1, 0);
`ifdef UCB_RX_TIMEOUT_EN
    repeat (9) step(1'b0, 4'h0, 1'b0, 1'b0);
    check("to_err", 64'(bus.rx_err), 64'd1);
    check("to_no_pkt", 64'(bus.pkt_vld), 64'd0);
    step(1'b0, 4'h0, 1'b0, 1'b1);
    send_beats({64'd0, H_RA}, 0, 15, -1, 0);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    check("to_next_vld", 64'(bus.pkt_vld), 64'd1);
    check("to_next_hdr", bus.pkt_hdr, H_RA);
`else
    repeat (100) step(1'b0, 4'h0, 1'b0, 1'b0);
    check("wait_err", 64'(bus.rx_err), 64'd0);
    check("wait_no_pkt", 64'(bus.pkt_vld), 64'd0);
    send_beats({64'd0, H_PART}, 5, 15, -1, 0);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    check("wait_vld", 64'(bus.pkt_vld), 64'd1);
    check("wait_hdr", bus.pkt_hdr, H_PART);
`endif
    pop_pkt();
    repeat (3) step(1'b0, 4'h0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
